// File: rtl/mem_stage_if.sv
// Byte-serial memory bus between the MEM stage (master) and the memory controller (slave).
// One byte moves per request; ready pulses for one cycle when the current byte completes.
interface mem_stage_if;
    logic        req;
    logic        wr;
    logic [31:0] addr;
    logic [7:0]  wdata;
    logic [7:0]  rdata;
    logic        ready;

    modport master (output req, output wr, output addr, output wdata,
                    input  rdata, input  ready);
    modport slave  (input  req, input  wr, input  addr, input  wdata,
                    output rdata, output ready);
endinterface

// File: rtl/mem_stage.sv
// MEM stage of the 5-stage RISC-V core: runs loads/stores as byte-serial bus transactions,
// extends load data and passes ALU results through for all other ops.
module mem_stage #(
    parameter logic [5:0] OP_LB  = 6'd20,
    parameter logic [5:0] OP_LH  = 6'd21,
    parameter logic [5:0] OP_LW  = 6'd22,
    parameter logic [5:0] OP_LBU = 6'd23,
    parameter logic [5:0] OP_LHU = 6'd24,
    parameter logic [5:0] OP_SB  = 6'd25,
    parameter logic [5:0] OP_SH  = 6'd26,
    parameter logic [5:0] OP_SW  = 6'd27
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [5:0]         op_in,
    input  logic               status_in,
    input  logic [31:0]        mem_address_in,
    input  logic [31:0]        target_data_in,
    input  logic [4:0]         reg_address_in,
    mem_stage_if.master        mem_bus,
    output logic               wb_en_o,
    output logic [4:0]         wb_addr_o,
    output logic [31:0]        wb_data_o,
    output logic               stall_req_o
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCESS,
        ST_DONE
    } state_t;

    state_t      state_q, state_d;
    logic [1:0]  cnt_q, cnt_d;
    logic [31:0] buf_q, buf_d;

    logic        is_mem;
    logic        is_load;
    logic [1:0]  last_idx;
    logic [31:0] load_ext;

    // Decode the op into access kind and index of the final byte (N-1).
    always_comb begin
        is_mem   = 1'b1;
        is_load  = 1'b1;
        last_idx = 2'd0;
        case (op_in)
            OP_LB, OP_LBU: last_idx = 2'd0;
            OP_LH, OP_LHU: last_idx = 2'd1;
            OP_LW:         last_idx = 2'd3;
            OP_SB: begin is_load = 1'b0; last_idx = 2'd0; end
            OP_SH: begin is_load = 1'b0; last_idx = 2'd1; end
            OP_SW: begin is_load = 1'b0; last_idx = 2'd3; end
            default: begin is_mem = 1'b0; is_load = 1'b0; end
        endcase
    end

    always_comb begin
        load_ext = buf_q;
        case (op_in)
            OP_LB:   load_ext = {{24{buf_q[7]}}, buf_q[7:0]};
            OP_LBU:  load_ext = {24'd0, buf_q[7:0]};
            OP_LH:   load_ext = {{16{buf_q[15]}}, buf_q[15:0]};
            OP_LHU:  load_ext = {16'd0, buf_q[15:0]};
            default: load_ext = buf_q;
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        buf_d   = buf_q;
        case (state_q)
            ST_IDLE: begin
                if (is_mem) begin
                    cnt_d   = 2'd0;
                    buf_d   = 32'd0;
                    state_d = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                if (mem_bus.ready) begin
                    if (is_load) begin
                        buf_d[{cnt_q, 3'b000} +: 8] = mem_bus.rdata;
                    end
                    cnt_d = cnt_q + 2'd1;
                    if (cnt_q == last_idx) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= 2'd0;
            buf_q   <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            buf_q   <= buf_d;
        end
    end

    // Outputs are gated by rst directly so a reset mid-access drops the request immediately.
    always_comb begin
        mem_bus.req   = 1'b0;
        mem_bus.wr    = 1'b0;
        mem_bus.addr  = 32'd0;
        mem_bus.wdata = 8'd0;
        wb_en_o       = 1'b0;
        wb_addr_o     = 5'd0;
        wb_data_o     = 32'd0;
        stall_req_o   = 1'b0;
        if (!rst) begin
            case (state_q)
                ST_IDLE: begin
                    if (is_mem) begin
                        stall_req_o = 1'b1;
                    end else begin
                        wb_en_o   = status_in;
                        wb_addr_o = reg_address_in;
                        wb_data_o = target_data_in;
                    end
                end
                ST_ACCESS: begin
                    mem_bus.req   = 1'b1;
                    mem_bus.wr    = ~is_load;
                    mem_bus.addr  = mem_address_in + {30'd0, cnt_q};
                    mem_bus.wdata = target_data_in[{cnt_q, 3'b000} +: 8];
                    stall_req_o   = 1'b1;
                end
                ST_DONE: begin
                    if (is_load) begin
                        wb_en_o   = status_in;
                        wb_addr_o = reg_address_in;
                        wb_data_o = load_ext;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Directed self-checking bench for mem_stage: reset, pass-through, loads with extension,
// a wrapping misaligned store with a slow controller, spurious ready, and reset mid-store.
module tb_mem_stage;
    localparam logic [5:0] OP_NOP = 6'd1;
    localparam logic [5:0] OP_LB  = 6'd20;
    localparam logic [5:0] OP_LH  = 6'd21;
    localparam logic [5:0] OP_LW  = 6'd22;
    localparam logic [5:0] OP_LBU = 6'd23;
    localparam logic [5:0] OP_SH  = 6'd26;
    localparam logic [5:0] OP_SW  = 6'd27;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  op_in;
    logic        status_in;
    logic [31:0] mem_address_in;
    logic [31:0] target_data_in;
    logic [4:0]  reg_address_in;
    logic        wb_en_o;
    logic [4:0]  wb_addr_o;
    logic [31:0] wb_data_o;
    logic        stall_req_o;

    int checks = 0;
    int errors = 0;
    int stallCycles;
    logic [31:0] expAddr;
    logic [7:0]  shBytes [2];

    mem_stage_if bus ();

    mem_stage dut (
        .clk            (clk),
        .rst            (rst),
        .op_in          (op_in),
        .status_in      (status_in),
        .mem_address_in (mem_address_in),
        .target_data_in (target_data_in),
        .reg_address_in (reg_address_in),
        .mem_bus        (bus),
        .wb_en_o        (wb_en_o),
        .wb_addr_o      (wb_addr_o),
        .wb_data_o      (wb_data_o),
        .stall_req_o    (stall_req_o)
    );

    always #5 clk = ~clk;

    task automatic applyStimulus(input logic [5:0] op, input logic status,
                                 input logic [31:0] addr, input logic [31:0] data,
                                 input logic [4:0] rd);
        op_in          = op;
        status_in      = status;
        mem_address_in = addr;
        target_data_in = data;
        reg_address_in = rd;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Load with ready tied high; bytes supplies the read data little-endian.
    task automatic runLoad(input string tag, input logic [5:0] op, input logic [31:0] addr,
                           input logic [31:0] bytes, input int n, input logic [31:0] exp,
                           input logic [4:0] rd);
        tick();
        applyStimulus(op, 1'b1, addr, 32'h5555_5555, rd);
        bus.ready   = 1'b1;
        stallCycles = 0;
        #1;
        checkOutput({tag, ".idleStall"}, stall_req_o, 1'b1);
        checkOutput({tag, ".idleWbEn"}, wb_en_o, 1'b0);
        if (stall_req_o) stallCycles++;
        for (int k = 0; k < n; k++) begin
            tick();
            bus.rdata = bytes[8*k +: 8];
            #1;
            checkOutput({tag, ".req"}, bus.req, 1'b1);
            checkOutput({tag, ".wr"}, bus.wr, 1'b0);
            checkOutput({tag, ".addr"}, bus.addr, addr + 32'(k));
            if (stall_req_o) stallCycles++;
        end
        tick();
        checkOutput({tag, ".doneStall"}, stall_req_o, 1'b0);
        checkOutput({tag, ".doneReq"}, bus.req, 1'b0);
        checkOutput({tag, ".doneWbEn"}, wb_en_o, 1'b1);
        checkOutput({tag, ".doneWbAddr"}, wb_addr_o, {27'd0, rd});
        checkOutput({tag, ".doneData"}, wb_data_o, exp);
        checkOutput({tag, ".stallCycles"}, stallCycles, n + 1);
        tick();
        applyStimulus(OP_NOP, 1'b0, 32'd0, 32'd0, 5'd0);
        bus.ready = 1'b0;
        #1;
        checkOutput({tag, ".backIdle"}, stall_req_o, 1'b0);
    endtask

    initial begin
        rst = 1'b1;
        applyStimulus(OP_NOP, 1'b1, 32'h0000_0040, 32'hCAFE_F00D, 5'd9);
        bus.rdata = 8'd0;
        bus.ready = 1'b0;
        #12;
        checkOutput("rst.wbEn", wb_en_o, 1'b0);
        checkOutput("rst.wbAddr", wb_addr_o, 32'd0);
        checkOutput("rst.wbData", wb_data_o, 32'd0);
        checkOutput("rst.stall", stall_req_o, 1'b0);
        checkOutput("rst.req", bus.req, 1'b0);

        @(negedge clk);
        rst = 1'b0;
        applyStimulus(OP_NOP, 1'b1, 32'd0, 32'h1234_5678, 5'd5);
        #1;
        checkOutput("pass.wbEn", wb_en_o, 1'b1);
        checkOutput("pass.wbAddr", wb_addr_o, 32'd5);
        checkOutput("pass.wbData", wb_data_o, 32'h1234_5678);
        checkOutput("pass.stall", stall_req_o, 1'b0);
        checkOutput("pass.req", bus.req, 1'b0);

        runLoad("lw",  OP_LW,  32'h0000_0100, 32'h1234_5678, 4, 32'h1234_5678, 5'd3);
        runLoad("lb",  OP_LB,  32'h0000_0007, 32'h0000_0080, 1, 32'hFFFF_FF80, 5'd4);
        runLoad("lbu", OP_LBU, 32'h0000_0007, 32'h0000_0080, 1, 32'h0000_0080, 5'd4);
        runLoad("lh",  OP_LH,  32'h0000_0002, 32'h0000_9234, 2, 32'hFFFF_9234, 5'd6);

        // SH across the address wrap, controller answers on the 4th cycle of each byte.
        shBytes[0] = 8'hEF;
        shBytes[1] = 8'hBE;
        tick();
        applyStimulus(OP_SH, 1'b1, 32'hFFFF_FFFF, 32'hAAAA_BEEF, 5'd7);
        bus.ready = 1'b0;
        #1;
        checkOutput("sh.idleStall", stall_req_o, 1'b1);
        tick();
        for (int k = 0; k < 2; k++) begin
            expAddr = 32'hFFFF_FFFF + 32'(k);
            for (int w = 0; w < 4; w++) begin
                checkOutput("sh.req", bus.req, 1'b1);
                checkOutput("sh.wr", bus.wr, 1'b1);
                checkOutput("sh.addr", bus.addr, expAddr);
                checkOutput("sh.wdata", bus.wdata, shBytes[k]);
                checkOutput("sh.stall", stall_req_o, 1'b1);
                if (w == 3) bus.ready = 1'b1;
                tick();
                bus.ready = 1'b0;
            end
        end
        checkOutput("sh.doneStall", stall_req_o, 1'b0);
        checkOutput("sh.doneReq", bus.req, 1'b0);
        checkOutput("sh.doneWbEn", wb_en_o, 1'b0);
        checkOutput("sh.doneWbData", wb_data_o, 32'd0);
        tick();
        applyStimulus(OP_NOP, 1'b1, 32'd0, 32'h0BAD_0BAD, 5'd4);

        // Ready pulse with no request outstanding must not start or advance anything.
        bus.ready = 1'b1;
        bus.rdata = 8'hFF;
        tick();
        bus.ready = 1'b0;
        #1;
        checkOutput("spur.req", bus.req, 1'b0);
        checkOutput("spur.stall", stall_req_o, 1'b0);
        checkOutput("spur.wbData", wb_data_o, 32'h0BAD_0BAD);
        runLoad("lbuAfterSpur", OP_LBU, 32'h0000_0010, 32'h0000_0001, 1, 32'h0000_0001, 5'd8);

        // SW interrupted by reset after two bytes have completed.
        tick();
        applyStimulus(OP_SW, 1'b1, 32'h0000_0200, 32'hDEAD_BEEF, 5'd2);
        bus.ready = 1'b1;
        bus.rdata = 8'd0;
        tick();
        checkOutput("sw.wdata0", bus.wdata, 8'hEF);
        tick();
        checkOutput("sw.wdata1", bus.wdata, 8'hBE);
        tick();
        checkOutput("sw.addr2", bus.addr, 32'h0000_0202);
        #1;
        rst = 1'b1;
        #1;
        checkOutput("swRst.req", bus.req, 1'b0);
        checkOutput("swRst.wr", bus.wr, 1'b0);
        checkOutput("swRst.addr", bus.addr, 32'd0);
        checkOutput("swRst.wdata", bus.wdata, 8'd0);
        checkOutput("swRst.stall", stall_req_o, 1'b0);
        checkOutput("swRst.wbEn", wb_en_o, 1'b0);
        applyStimulus(OP_NOP, 1'b1, 32'd0, 32'h0000_1111, 5'd1);
        tick();
        rst = 1'b0;
        #1;
        checkOutput("swPost.req", bus.req, 1'b0);
        checkOutput("swPost.stall", stall_req_o, 1'b0);
        checkOutput("swPost.wbData", wb_data_o, 32'h0000_1111);
        tick();
        checkOutput("swPost.req2", bus.req, 1'b0);
        bus.ready = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
